// File: rtl/mul_iq_pkg.sv
// rtl/mul_iq_pkg.sv - shared sizes, entry layout and FSM states for the multiply issue queue
package mul_iq_pkg;
   localparam int IQ_DEPTH = 4;
   localparam int IQ_TAG_W = 4;
   localparam int IQ_XLEN  = 32;
   localparam int IQ_AGE_W = $clog2(IQ_DEPTH) + 1;

   typedef enum logic [1:0] {IQ_IDLE, IQ_BUSY, IQ_DRAIN} iq_state_e;

   typedef struct packed {
      logic                rdy;
      logic [IQ_TAG_W-1:0] tag;
      logic [IQ_XLEN-1:0]  val;
   } opnd_t;

   typedef struct packed {
      logic                valid;
      logic [IQ_XLEN-1:0]  pc;
      logic [31:0]         inst;
      logic [IQ_TAG_W-1:0] tag;
      opnd_t               rs1;
      opnd_t               rs2;
      logic [IQ_AGE_W-1:0] age;
   } entry_t;

   // Capture a broadcast result into an operand still waiting on that producer tag.
   function automatic opnd_t wake(input opnd_t o, input logic cdb_valid,
                                  input logic [IQ_TAG_W-1:0] cdb_tag,
                                  input logic [IQ_XLEN-1:0] cdb_value);
      opnd_t r;
      r = o;
      if (!o.rdy && cdb_valid && (o.tag == cdb_tag)) begin
         r.rdy = 1'b1;
         r.val = cdb_value;
      end
      return r;
   endfunction
endpackage

// File: rtl/mul_iq_oldest_sel.sv
// rtl/mul_iq_oldest_sel.sv - combinational oldest-ready picker, one-hot grant
module mul_iq_oldest_sel #(
   parameter int DEPTH = 4,
   parameter int AGE_W = 3
) (
   input  logic [DEPTH-1:0]            ready_i,
   input  logic [DEPTH-1:0][AGE_W-1:0] age_i,
   output logic [DEPTH-1:0]            grant_o,
   output logic                        any_o
);
   // Ages are distinct ranks among live entries, so exactly one ready entry survives.
   always_comb begin
      grant_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         grant_o[i] = ready_i[i];
         for (int j = 0; j < DEPTH; j++) begin
            if ((j != i) && ready_i[j] && (age_i[j] > age_i[i])) grant_o[i] = 1'b0;
         end
      end
   end

   assign any_o = |ready_i;
endmodule

// File: rtl/mul_issue_queue.sv
// rtl/mul_issue_queue.sv - multiply issue queue: buffers ops, wakes operands off the CDB,
// issues the oldest ready op to mul and tags its writeback.
module mul_issue_queue
   import mul_iq_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH,
   parameter int TAG_W = IQ_TAG_W,
   parameter int XLEN  = IQ_XLEN
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             flush_i,
   input  logic             dispatch_valid_i,
   output logic             dispatch_ready_o,
   input  logic [XLEN-1:0]  dispatch_pc_i,
   input  logic [31:0]      dispatch_inst_i,
   input  logic [TAG_W-1:0] dispatch_tag_i,
   input  logic             rs1_ready_i,
   input  logic [TAG_W-1:0] rs1_tag_i,
   input  logic [XLEN-1:0]  rs1_value_i,
   input  logic             rs2_ready_i,
   input  logic [TAG_W-1:0] rs2_tag_i,
   input  logic [XLEN-1:0]  rs2_value_i,
   input  logic             cdb_valid_i,
   input  logic [TAG_W-1:0] cdb_tag_i,
   input  logic [XLEN-1:0]  cdb_value_i,
   output logic             mul_request_o,
   output logic [XLEN-1:0]  mul_pc_o,
   output logic [31:0]      mul_inst_o,
   output logic [XLEN-1:0]  mul_rs1_value_o,
   output logic [XLEN-1:0]  mul_rs2_value_o,
   input  logic             writeback_valid_i,
   input  logic [XLEN-1:0]  writeback_value_i,
   output logic             result_valid_o,
   output logic [TAG_W-1:0] result_tag_o,
   output logic [XLEN-1:0]  result_value_o
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   entry_t [DEPTH-1:0]  ent_q, ent_d;
   logic [CNT_W-1:0]    count_q, count_d;
   iq_state_e           state_q, state_d;
   logic [TAG_W-1:0]    inflight_tag_q, inflight_tag_d;
   logic                result_valid_q, result_valid_d;
   logic [TAG_W-1:0]    result_tag_q, result_tag_d;
   logic [XLEN-1:0]     result_value_q, result_value_d;

   logic [DEPTH-1:0]               rdy_vec, grant, free_oh;
   logic [DEPTH-1:0][IQ_AGE_W-1:0] age_vec;
   logic                           any_rdy, issue, deliver, accept;
   logic [XLEN-1:0]                sel_pc, sel_rs1, sel_rs2;
   logic [31:0]                    sel_inst;
   logic [TAG_W-1:0]               sel_tag;
   logic [IQ_AGE_W-1:0]            sel_age;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         rdy_vec[i] = ent_q[i].valid && ent_q[i].rs1.rdy && ent_q[i].rs2.rdy;
         age_vec[i] = ent_q[i].age;
      end
   end

   mul_iq_oldest_sel #(.DEPTH(DEPTH), .AGE_W(IQ_AGE_W)) u_sel (
      .ready_i (rdy_vec),
      .age_i   (age_vec),
      .grant_o (grant),
      .any_o   (any_rdy)
   );

   always_comb begin
      sel_pc   = '0;
      sel_inst = '0;
      sel_rs1  = '0;
      sel_rs2  = '0;
      sel_tag  = '0;
      sel_age  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (grant[i]) begin
            sel_pc   = ent_q[i].pc;
            sel_inst = ent_q[i].inst;
            sel_rs1  = ent_q[i].rs1.val;
            sel_rs2  = ent_q[i].rs2.val;
            sel_tag  = ent_q[i].tag;
            sel_age  = ent_q[i].age;
         end
      end
   end

   always_comb begin
      logic found;
      found   = 1'b0;
      free_oh = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!ent_q[i].valid && !found) begin
            free_oh[i] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   assign dispatch_ready_o = (count_q < CNT_W'(DEPTH)) && (state_q != IQ_DRAIN);
   assign accept           = dispatch_valid_i && dispatch_ready_o && !flush_i;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IQ_IDLE:  if (any_rdy && !flush_i) state_d = IQ_BUSY;
         IQ_BUSY:  if (writeback_valid_i) state_d = IQ_IDLE;
                   else if (flush_i)      state_d = IQ_DRAIN;
         IQ_DRAIN: if (writeback_valid_i) state_d = IQ_IDLE;
         default:  state_d = IQ_IDLE;
      endcase
   end

   always_comb begin
      issue   = (state_q == IQ_IDLE) && any_rdy && !flush_i;
      deliver = (state_q == IQ_BUSY) && writeback_valid_i && !flush_i;
   end

   assign mul_request_o   = issue;
   assign mul_pc_o        = issue ? sel_pc   : '0;
   assign mul_inst_o      = issue ? sel_inst : '0;
   assign mul_rs1_value_o = issue ? sel_rs1  : '0;
   assign mul_rs2_value_o = issue ? sel_rs2  : '0;

   // Age is a rank: number of younger live entries; oldest holds the largest value.
   always_comb begin
      ent_d = ent_q;
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i].rs1 = wake(ent_q[i].rs1, cdb_valid_i, cdb_tag_i, cdb_value_i);
         ent_d[i].rs2 = wake(ent_q[i].rs2, cdb_valid_i, cdb_tag_i, cdb_value_i);
         if (accept) ent_d[i].age = ent_d[i].age + IQ_AGE_W'(1);
         if (issue && (ent_q[i].age > sel_age)) ent_d[i].age = ent_d[i].age - IQ_AGE_W'(1);
         if (issue && grant[i]) ent_d[i].valid = 1'b0;
         if (accept && free_oh[i]) begin
            ent_d[i].valid = 1'b1;
            ent_d[i].pc    = dispatch_pc_i;
            ent_d[i].inst  = dispatch_inst_i;
            ent_d[i].tag   = dispatch_tag_i;
            ent_d[i].rs1   = wake('{rdy: rs1_ready_i, tag: rs1_tag_i, val: rs1_value_i},
                                  cdb_valid_i, cdb_tag_i, cdb_value_i);
            ent_d[i].rs2   = wake('{rdy: rs2_ready_i, tag: rs2_tag_i, val: rs2_value_i},
                                  cdb_valid_i, cdb_tag_i, cdb_value_i);
            ent_d[i].age   = '0;
         end
         if (flush_i) ent_d[i].valid = 1'b0;
      end
   end

   always_comb begin
      count_d        = flush_i ? '0 : count_q + CNT_W'(accept) - CNT_W'(issue);
      inflight_tag_d = issue ? sel_tag : inflight_tag_q;
      result_valid_d = deliver;
      result_tag_d   = deliver ? inflight_tag_q : '0;
      result_value_d = deliver ? writeback_value_i : '0;
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         ent_q          <= '0;
         count_q        <= '0;
         state_q        <= IQ_IDLE;
         inflight_tag_q <= '0;
         result_valid_q <= 1'b0;
         result_tag_q   <= '0;
         result_value_q <= '0;
      end else begin
         ent_q          <= ent_d;
         count_q        <= count_d;
         state_q        <= state_d;
         inflight_tag_q <= inflight_tag_d;
         result_valid_q <= result_valid_d;
         result_tag_q   <= result_tag_d;
         result_value_q <= result_value_d;
      end
   end

   assign result_valid_o = result_valid_q;
   assign result_tag_o   = result_tag_q;
   assign result_value_o = result_value_q;
endmodule

// File: tb/tb_mul_issue_queue.sv
// tb/tb_mul_issue_queue.sv - directed self-checking bench for mul_issue_queue
module tb_mul_issue_queue;
   logic        clk_i, reset_i, flush_i;
   logic        dispatch_valid_i, dispatch_ready_o;
   logic [31:0] dispatch_pc_i, dispatch_inst_i;
   logic [3:0]  dispatch_tag_i;
   logic        rs1_ready_i, rs2_ready_i;
   logic [3:0]  rs1_tag_i, rs2_tag_i;
   logic [31:0] rs1_value_i, rs2_value_i;
   logic        cdb_valid_i;
   logic [3:0]  cdb_tag_i;
   logic [31:0] cdb_value_i;
   logic        mul_request_o;
   logic [31:0] mul_pc_o, mul_inst_o, mul_rs1_value_o, mul_rs2_value_o;
   logic        writeback_valid_i;
   logic [31:0] writeback_value_i;
   logic        result_valid_o;
   logic [3:0]  result_tag_o;
   logic [31:0] result_value_o;

   int n_total = 0;
   int n_pass  = 0;

   mul_issue_queue dut (
      .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
      .dispatch_valid_i(dispatch_valid_i), .dispatch_ready_o(dispatch_ready_o),
      .dispatch_pc_i(dispatch_pc_i), .dispatch_inst_i(dispatch_inst_i),
      .dispatch_tag_i(dispatch_tag_i),
      .rs1_ready_i(rs1_ready_i), .rs1_tag_i(rs1_tag_i), .rs1_value_i(rs1_value_i),
      .rs2_ready_i(rs2_ready_i), .rs2_tag_i(rs2_tag_i), .rs2_value_i(rs2_value_i),
      .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_value_i(cdb_value_i),
      .mul_request_o(mul_request_o), .mul_pc_o(mul_pc_o), .mul_inst_o(mul_inst_o),
      .mul_rs1_value_o(mul_rs1_value_o), .mul_rs2_value_o(mul_rs2_value_o),
      .writeback_valid_i(writeback_valid_i), .writeback_value_i(writeback_value_i),
      .result_valid_o(result_valid_o), .result_tag_o(result_tag_o),
      .result_value_o(result_value_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clr_inputs();
      flush_i = 0; dispatch_valid_i = 0; dispatch_pc_i = 0; dispatch_inst_i = 0;
      dispatch_tag_i = 0; rs1_ready_i = 0; rs1_tag_i = 0; rs1_value_i = 0;
      rs2_ready_i = 0; rs2_tag_i = 0; rs2_value_i = 0; cdb_valid_i = 0; cdb_tag_i = 0;
      cdb_value_i = 0; writeback_valid_i = 0; writeback_value_i = 0;
   endtask

   task automatic offer(input logic [31:0] pc, input logic [3:0] tag,
                        input logic r1, input logic [3:0] t1, input logic [31:0] v1,
                        input logic r2, input logic [3:0] t2, input logic [31:0] v2);
      dispatch_valid_i = 1; dispatch_pc_i = pc; dispatch_inst_i = 32'h02b5_0533;
      dispatch_tag_i = tag;
      rs1_ready_i = r1; rs1_tag_i = t1; rs1_value_i = v1;
      rs2_ready_i = r2; rs2_tag_i = t2; rs2_value_i = v2;
   endtask

   // Wait for the next issue, act as mul, and check the tagged result comes back.
   task automatic serve(input string nm, input logic [31:0] exp_pc, input logic [3:0] exp_tag,
                        input logic [31:0] wb);
      int n = 0;
      while (!mul_request_o && n < 20) begin
         step();
         n++;
      end
      check({nm, "_req"}, mul_request_o, 1);
      check({nm, "_pc"}, mul_pc_o, exp_pc);
      step();
      writeback_valid_i = 1; writeback_value_i = wb;
      step();
      writeback_valid_i = 0;
      #1;
      check({nm, "_res_v"}, result_valid_o, 1);
      check({nm, "_res_tag"}, result_tag_o, exp_tag);
      check({nm, "_res_val"}, result_value_o, wb);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset_i = 0;
      clr_inputs();
      step(); step();
      check("rst_req", mul_request_o, 0);
      check("rst_res_v", result_valid_o, 0);
      check("rst_res_tag", result_tag_o, 0);
      check("rst_rs1", mul_rs1_value_o, 0);
      reset_i = 1;
      step();
      check("rst_rdy", dispatch_ready_o, 1);

      // basic issue and writeback
      offer(32'h100, 4'd2, 1, 0, 3, 1, 0, 5);
      #1;
      check("t2_rdy", dispatch_ready_o, 1);
      check("t2_noreq", mul_request_o, 0);
      step();
      dispatch_valid_i = 0;
      #1;
      check("t2_req", mul_request_o, 1);
      check("t2_rs1", mul_rs1_value_o, 3);
      check("t2_rs2", mul_rs2_value_o, 5);
      check("t2_pc", mul_pc_o, 32'h100);
      check("t2_inst", mul_inst_o, 32'h02b5_0533);
      step();
      check("t2_busy_noreq", mul_request_o, 0);
      writeback_valid_i = 1; writeback_value_i = 15;
      step();
      writeback_valid_i = 0;
      #1;
      check("t2_res_v", result_valid_o, 1);
      check("t2_res_tag", result_tag_o, 2);
      check("t2_res_val", result_value_o, 15);
      step();
      check("t2_res_once", result_valid_o, 0);
      writeback_valid_i = 1; writeback_value_i = 77;
      step();
      writeback_valid_i = 0;
      #1;
      check("idle_wb_ignored", result_valid_o, 0);

      // younger ready op overtakes older waiting op
      offer(32'h200, 4'd3, 0, 7, 0, 1, 0, 4);
      step();
      offer(32'h204, 4'd4, 1, 0, 2, 1, 0, 6);
      #1;
      check("t3_noreq", mul_request_o, 0);
      step();
      dispatch_valid_i = 0;
      cdb_valid_i = 1; cdb_tag_i = 7; cdb_value_i = 9;
      #1;
      check("t3_b_req", mul_request_o, 1);
      check("t3_b_pc", mul_pc_o, 32'h204);
      check("t3_b_rs1", mul_rs1_value_o, 2);
      check("t3_b_rs2", mul_rs2_value_o, 6);
      step();
      cdb_valid_i = 0;
      #1;
      check("t3_busy", mul_request_o, 0);
      writeback_valid_i = 1; writeback_value_i = 12;
      step();
      writeback_valid_i = 0;
      #1;
      check("t3_b_res_tag", result_tag_o, 4);
      check("t3_b_res_val", result_value_o, 12);
      check("t3_a_req", mul_request_o, 1);
      check("t3_a_pc", mul_pc_o, 32'h200);
      check("t3_a_rs1", mul_rs1_value_o, 9);
      check("t3_a_rs2", mul_rs2_value_o, 4);
      step();
      writeback_valid_i = 1; writeback_value_i = 36;
      step();
      writeback_valid_i = 0;
      #1;
      check("t3_a_res_tag", result_tag_o, 3);
      check("t3_a_res_val", result_value_o, 36);

      // operand captured from CDB in the dispatch cycle
      offer(32'h300, 4'd8, 1, 0, 2, 0, 6, 0);
      cdb_valid_i = 1; cdb_tag_i = 6; cdb_value_i = 32'hFFFF_FFFF;
      step();
      dispatch_valid_i = 0; cdb_valid_i = 0;
      #1;
      check("t5_req", mul_request_o, 1);
      check("t5_rs1", mul_rs1_value_o, 2);
      check("t5_rs2", mul_rs2_value_o, 32'hFFFF_FFFF);
      step();
      writeback_valid_i = 1; writeback_value_i = 32'hFFFF_FFFE;
      step();
      writeback_valid_i = 0;
      #1;
      check("t5_res_tag", result_tag_o, 8);
      check("t5_res_val", result_value_o, 32'hFFFF_FFFE);

      // fill the queue, hold a fifth offer until a slot frees
      for (int i = 0; i < 4; i++) begin
         offer(32'h410 + 4 * i, 4'(10 + i), 0, 9, 0, 1, 0, i);
         #1;
         check("t4_rdy_fill", dispatch_ready_o, 1);
         step();
      end
      offer(32'h500, 4'd5, 1, 0, 7, 1, 0, 8);
      #1;
      check("t4_full", dispatch_ready_o, 0);
      check("t4_noreq", mul_request_o, 0);
      step();
      check("t4_held", dispatch_ready_o, 0);
      cdb_valid_i = 1; cdb_tag_i = 9; cdb_value_i = 1;
      step();
      cdb_valid_i = 0;
      #1;
      check("t4_e1_req", mul_request_o, 1);
      check("t4_e1_pc", mul_pc_o, 32'h410);
      check("t4_e1_rs1", mul_rs1_value_o, 1);
      check("t4_rdy_issue_cycle", dispatch_ready_o, 0);
      step();
      check("t4_rdy_after_free", dispatch_ready_o, 1);
      writeback_valid_i = 1; writeback_value_i = 100;
      step();
      dispatch_valid_i = 0; writeback_valid_i = 0;
      #1;
      check("t4_e1_res_tag", result_tag_o, 10);
      check("t4_e1_res_val", result_value_o, 100);
      serve("t4_e2", 32'h414, 4'd11, 101);
      serve("t4_e3", 32'h418, 4'd12, 102);
      serve("t4_e4", 32'h41C, 4'd13, 103);
      serve("t4_e5", 32'h500, 4'd5, 104);

      // flush while BUSY, drain discards the in-flight result
      offer(32'h600, 4'd6, 1, 0, 1, 1, 0, 2);
      step();
      offer(32'h604, 4'd7, 0, 12, 0, 1, 0, 3);
      #1;
      check("t6_req", mul_request_o, 1);
      step();
      offer(32'h608, 4'd9, 1, 0, 5, 1, 0, 5);
      flush_i = 1;
      #1;
      check("t6_flush_noreq", mul_request_o, 0);
      step();
      flush_i = 0; dispatch_valid_i = 0;
      #1;
      check("t6_drain_rdy", dispatch_ready_o, 0);
      writeback_valid_i = 1; writeback_value_i = 42;
      step();
      writeback_valid_i = 0;
      #1;
      check("t6_no_result", result_valid_o, 0);
      check("t6_idle_rdy", dispatch_ready_o, 1);
      cdb_valid_i = 1; cdb_tag_i = 12; cdb_value_i = 3;
      step();
      cdb_valid_i = 0;
      #1;
      check("t6_empty", mul_request_o, 0);
      step();
      check("t6_empty2", mul_request_o, 0);

      // asynchronous reset with a result and an issue both visible
      offer(32'h700, 4'd1, 1, 0, 6, 1, 0, 7);
      step();
      offer(32'h704, 4'd2, 1, 0, 1, 1, 0, 1);
      #1;
      check("t1_first_req", mul_request_o, 1);
      step();
      dispatch_valid_i = 0;
      writeback_valid_i = 1; writeback_value_i = 42;
      step();
      writeback_valid_i = 0;
      #1;
      check("t1_pre_res", result_valid_o, 1);
      check("t1_pre_req", mul_request_o, 1);
      #2;
      reset_i = 0;
      #1;
      check("t1_rst_res_v", result_valid_o, 0);
      check("t1_rst_res_val", result_value_o, 0);
      check("t1_rst_req", mul_request_o, 0);
      check("t1_rst_rs1", mul_rs1_value_o, 0);
      step();
      reset_i = 1;
      step();
      check("t1_rdy", dispatch_ready_o, 1);
      check("t1_q_empty", mul_request_o, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
